// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network output decoder: FSM state
// encoding, index-width helper and the "no spike" first-time sentinel.
package snn_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Winner index width: clog2 of the channel count, but never narrower than one bit.
   function automatic int idx_width(input int n_ch);
      if (n_ch <= 2) return 1;
      return $clog2(n_ch);
   endfunction

   // A first-spike field equal to the window length means the channel never fired.
   function automatic int no_spike(input int window);
      return window;
   endfunction

endpackage

// File: rtl/spike_channel_counter.sv
// Per-channel spike counter with first-spike time capture. Cleared at the
// start of each window; accumulates only while sample_en is high.
module spike_channel_counter
   import snn_pkg::*;
#(
   parameter int WINDOW = 16,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             sample_en,
   input  logic             spike,
   input  logic [CNT_W-1:0] cyc,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] first
);

   localparam logic [CNT_W-1:0] NONE = CNT_W'(no_spike(WINDOW));

   // Count spikes and latch the cycle index of the first one; counts cannot
   // exceed the window length, so no saturation is needed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         first <= '0;
      end else if (clear) begin
         count <= '0;
         first <= NONE;
      end else if (sample_en && spike) begin
         count <= count + 1'b1;
         if (first == NONE) begin
            first <= cyc;
         end
      end
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts spikes per channel over a fixed window, records
// first-spike times, picks a winner and offers the result on valid/ready.
//
// Handshake: out_valid rises when a result is ready and stays high, with all
// result outputs frozen, until an edge sees out_valid && out_ready; that edge
// completes the transfer. start on the same edge restarts immediately.
module spike_rate_decoder
   import snn_pkg::*;
#(
   parameter int N_CH   = 3,
   parameter int WINDOW = 16,
   parameter int CNT_W  = 8,
   parameter int IDX_W  = idx_width(N_CH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [N_CH-1:0]       spike_in,
   output logic                  busy,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N_CH*CNT_W-1:0] count_flat,
   output logic [N_CH*CNT_W-1:0] first_flat,
   output logic [IDX_W-1:0]      winner,
   output logic                  winner_valid
);

   localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(WINDOW - 1);

   state_t           state;
   logic [CNT_W-1:0] cyc;
   logic             clear;
   logic             sample_en;
   logic [CNT_W-1:0] cnt_a   [N_CH];
   logic [CNT_W-1:0] first_a [N_CH];
   logic [IDX_W-1:0] best_idx;
   logic [CNT_W-1:0] best_cnt;
   logic [CNT_W-1:0] best_first;
   logic             any_spike;

   // Counters clear whenever a new window is accepted, from IDLE or as a
   // back-to-back restart on the completing handshake edge.
   always_comb begin
      clear     = 1'b0;
      sample_en = 1'b0;
      if (state == IDLE && start) begin
         clear = 1'b1;
      end
      if (state == DONE && out_ready && start) begin
         clear = 1'b1;
      end
      if (state == COUNT) begin
         sample_en = 1'b1;
      end
   end

   genvar g;
   generate
      for (g = 0; g < N_CH; g++) begin : g_ch
         spike_channel_counter #(
            .WINDOW (WINDOW),
            .CNT_W  (CNT_W)
         ) u_cnt (
            .clk       (clk),
            .reset_n   (reset_n),
            .clear     (clear),
            .sample_en (sample_en),
            .spike     (spike_in[g]),
            .cyc       (cyc),
            .count     (cnt_a[g]),
            .first     (first_a[g])
         );
         assign count_flat[g*CNT_W +: CNT_W] = cnt_a[g];
         assign first_flat[g*CNT_W +: CNT_W] = first_a[g];
      end
   endgenerate

   // Winner search: higher count wins, then earlier first spike; a strict
   // comparison leaves remaining ties with the lower index.
   always_comb begin
      best_idx   = '0;
      best_cnt   = cnt_a[0];
      best_first = first_a[0];
      any_spike  = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (cnt_a[i] != '0) begin
            any_spike = 1'b1;
         end
         if (i > 0) begin
            if ((cnt_a[i] > best_cnt) ||
                ((cnt_a[i] == best_cnt) && (first_a[i] < best_first))) begin
               best_idx   = IDX_W'(i);
               best_cnt   = cnt_a[i];
               best_first = first_a[i];
            end
         end
      end
   end

   // Control FSM with registered busy/out_valid/winner outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cyc          <= '0;
         busy         <= 1'b0;
         out_valid    <= 1'b0;
         winner       <= '0;
         winner_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= COUNT;
                  cyc   <= '0;
                  busy  <= 1'b1;
               end
            end
            COUNT: begin
               cyc <= cyc + 1'b1;
               if (cyc == LAST_CYC) begin
                  state <= RESOLVE;
               end
            end
            RESOLVE: begin
               winner       <= best_idx;
               winner_valid <= any_spike;
               out_valid    <= 1'b1;
               state        <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (start) begin
                     state <= COUNT;
                     cyc   <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomised and directed bench for spike_rate_decoder with a behavioural
// reference model and an expected-result queue.
module tb_spike_rate_decoder;

   localparam int N_CH   = 3;
   localparam int WINDOW = 16;
   localparam int CNT_W  = 8;
   localparam int IDX_W  = 2;
   localparam int FW     = N_CH * CNT_W;
   localparam int RES_W  = 1 + IDX_W + 2 * FW;

   logic              clk;
   logic              reset_n;
   logic              start;
   logic [N_CH-1:0]   spike_in;
   logic              busy;
   logic              out_valid;
   logic              out_ready;
   logic [FW-1:0]     count_flat;
   logic [FW-1:0]     first_flat;
   logic [IDX_W-1:0]  winner;
   logic              winner_valid;

   int n_checks = 0;
   int n_fail   = 0;

   logic [N_CH-1:0]  pat [WINDOW];
   logic [RES_W-1:0] exp_q [$];

   spike_rate_decoder #(
      .N_CH   (N_CH),
      .WINDOW (WINDOW),
      .CNT_W  (CNT_W)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .spike_in     (spike_in),
      .busy         (busy),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .count_flat   (count_flat),
      .first_flat   (first_flat),
      .winner       (winner),
      .winner_valid (winner_valid)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reference model: counts, first-spike times and winner from the pattern.
   function automatic logic [RES_W-1:0] model_result();
      int cnt [N_CH];
      int fst [N_CH];
      int win;
      logic wv;
      logic [FW-1:0] cf;
      logic [FW-1:0] ff;
      bit beaten;
      win = 0;
      wv  = 1'b0;
      cf  = '0;
      ff  = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         cnt[ch] = 0;
         fst[ch] = WINDOW;
         for (int c = WINDOW - 1; c >= 0; c--) begin
            if (pat[c][ch]) begin
               cnt[ch] = cnt[ch] + 1;
               fst[ch] = c;
            end
         end
         if (cnt[ch] > 0) wv = 1'b1;
         cf[ch*CNT_W +: CNT_W] = CNT_W'(cnt[ch]);
         ff[ch*CNT_W +: CNT_W] = CNT_W'(fst[ch]);
      end
      // A channel wins when no other channel outranks it.
      for (int i = 0; i < N_CH; i++) begin
         beaten = 1'b0;
         for (int j = 0; j < N_CH; j++) begin
            if (j != i) begin
               if (cnt[j] > cnt[i]) beaten = 1'b1;
               else if (cnt[j] == cnt[i] && fst[j] < fst[i]) beaten = 1'b1;
               else if (cnt[j] == cnt[i] && fst[j] == fst[i] && j < i) beaten = 1'b1;
            end
         end
         if (!beaten) win = i;
      end
      return {wv, IDX_W'(win), ff, cf};
   endfunction

   task automatic check_result(input string tag, input logic [RES_W-1:0] exp);
      logic [RES_W-1:0] got;
      got = {winner_valid, winner, first_flat, count_flat};
      check({tag, "_count"}, 64'(got[FW-1:0]), 64'(exp[FW-1:0]));
      check({tag, "_first"}, 64'(got[2*FW-1:FW]), 64'(exp[2*FW-1:FW]));
      check({tag, "_winner"}, 64'(got[2*FW+IDX_W-1:2*FW]), 64'(exp[2*FW+IDX_W-1:2*FW]));
      check({tag, "_wvalid"}, 64'(got[RES_W-1]), 64'(exp[RES_W-1]));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_ovalid"}, 64'(out_valid), 64'd0);
      check({tag, "_count"}, 64'(count_flat), 64'd0);
      check({tag, "_first"}, 64'(first_flat), 64'd0);
      check({tag, "_winner"}, 64'(winner), 64'd0);
      check({tag, "_wvalid"}, 64'(winner_valid), 64'd0);
   endtask

   // Assert reset between edges, check outputs clear at once, then release.
   task automatic reset_mid(input string tag);
      #2 reset_n = 1'b0;
      #1 check_all_zero({tag, "_imm"});
      @(negedge clk);
      check_all_zero({tag, "_held"});
      reset_n  = 1'b1;
      start    = 1'b0;
      spike_in = N_CH'($urandom);
      step();
      check({tag, "_idle_busy"}, 64'(busy), 64'd0);
   endtask

   // driver: one full window. abort_at in [0,WINDOW-1] resets mid-count,
   // abort_at == WINDOW resets while the result is pending.
   task automatic run_window(input bit issue_start, input int hold, input bit chain,
                             input int abort_at);
      logic [RES_W-1:0] exp;
      if (issue_start) begin
         start     = 1'b1;
         out_ready = 1'b0;
         spike_in  = N_CH'($urandom);
         step();
      end
      exp_q.push_back(model_result());
      for (int c = 0; c < WINDOW; c++) begin
         check("count_busy", 64'(busy), 64'd1);
         check("count_ovalid", 64'(out_valid), 64'd0);
         if (c == abort_at) begin
            void'(exp_q.pop_front());
            reset_mid("rst_count");
            return;
         end
         start    = 1'($urandom);
         spike_in = pat[c];
         step();
      end
      check("resolve_busy", 64'(busy), 64'd1);
      check("resolve_ovalid", 64'(out_valid), 64'd0);
      start    = 1'($urandom);
      spike_in = N_CH'($urandom);
      step();
      check("done_ovalid", 64'(out_valid), 64'd1);
      check("done_busy", 64'(busy), 64'd1);
      exp = exp_q.pop_front();
      check_result("result", exp);
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         start     = 1'($urandom);
         spike_in  = N_CH'($urandom);
         step();
         check("hold_ovalid", 64'(out_valid), 64'd1);
         check_result("hold", exp);
      end
      if (abort_at == WINDOW) begin
         reset_mid("rst_done");
         return;
      end
      out_ready = 1'b1;
      start     = chain;
      spike_in  = N_CH'($urandom);
      step();
      out_ready = 1'b0;
      start     = 1'b0;
      check("hs_ovalid", 64'(out_valid), 64'd0);
      check("hs_busy", 64'(busy), 64'(chain));
   endtask

   task automatic set_random_pat();
      for (int c = 0; c < WINDOW; c++) begin
         pat[c] = N_CH'($urandom) & N_CH'($urandom_range(0, 7));
      end
   endtask

   task automatic set_pat_from(input logic [WINDOW-1:0] c0, input logic [WINDOW-1:0] c1,
                               input logic [WINDOW-1:0] c2);
      for (int c = 0; c < WINDOW; c++) begin
         pat[c] = {c2[c], c1[c], c0[c]};
      end
   endtask

   initial begin
      bit chained;
      reset_n   = 1'b0;
      start     = 1'b0;
      spike_in  = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset_n = 1'b1;
      step();
      check("idle_busy", 64'(busy), 64'd0);

      // basic: ch0 every cycle, ch1 at 0,4,8,12, ch2 silent
      set_pat_from(16'hFFFF, 16'h1111, 16'h0000);
      run_window(1'b1, 0, 1'b0, -1);
      check("basic_winner_const", 64'(winner), 64'd0);

      // tie on count, earlier first spike on ch2 wins
      set_pat_from(16'h0001, 16'h0AA8, 16'h003E);
      run_window(1'b1, 1, 1'b0, -1);
      check("tie1_winner_const", 64'(winner), 64'd2);

      // full tie on ch1/ch2, lower index wins
      set_pat_from(16'h0001, 16'h0444, 16'h0444);
      run_window(1'b1, 0, 1'b0, -1);
      check("tie2_winner_const", 64'(winner), 64'd1);

      // silent window
      set_pat_from(16'h0000, 16'h0000, 16'h0000);
      run_window(1'b1, 0, 1'b0, -1);
      check("silent_wvalid_const", 64'(winner_valid), 64'd0);

      // backpressure for 10 cycles, then back-to-back restart
      set_random_pat();
      run_window(1'b1, 10, 1'b1, -1);
      set_random_pat();
      run_window(1'b0, 0, 1'b0, -1);

      // reset mid-window at cyc 7, then a fresh window
      set_pat_from(16'hFFFF, 16'hFFFF, 16'hFFFF);
      run_window(1'b1, 0, 1'b0, 7);
      set_pat_from(16'h0003, 16'h0000, 16'h8000);
      run_window(1'b1, 0, 1'b0, -1);

      // reset while a result is pending
      set_random_pat();
      run_window(1'b1, 2, 1'b0, WINDOW);

      // randomised windows with random backpressure and chaining
      chained = 1'b0;
      for (int n = 0; n < 20; n++) begin
         bit ch;
         ch = 1'($urandom);
         set_random_pat();
         run_window(!chained, $urandom_range(0, 4), ch, -1);
         chained = ch;
      end
      if (chained) begin
         set_random_pat();
         run_window(1'b0, 0, 1'b0, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
